fifo_ctrl_dp: RTL and testbench

// - Synchronous FIFO controller driving an external simple dual-port block RAM
//   (1 write port, 1 read port, registered read data, 1-cycle read latency).
// - Upstream/downstream valid/ready streams; first-word-fall-through output.
// - Owns pointers, occupancy and prefetch. A 2-entry output skid absorbs RAM

---
 rtl/fifo_ctrl_dp.sv | 152 +++++++++++++++
 tb/tb_fifo_ctrl_dp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_dp.sv
// FIFO controller for an external simple dual-port RAM with 1-cycle registered read.
// Output side is first-word-fall-through through a 2-entry skid that hides the read latency.
module fifo_ctrl_dp #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDRWIDTH+1:0] level,
  output logic                 ram_enable,
  output logic [DATAWIDTH-1:0] ram_wr_data,
  output logic [ADDRWIDTH-1:0] ram_wr_addr,
  output logic                 ram_we,
  output logic [ADDRWIDTH-1:0] ram_rd_addr,
  input  logic [DATAWIDTH-1:0] ram_rd_data
);

  localparam int CW = ADDRWIDTH + 1;
  localparam int LW = ADDRWIDTH + 2;

  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        ram_cnt_q, ram_cnt_d;
  logic                 rd_inflight_q, rd_inflight_d;
  logic [1:0]           skid_cnt_q, skid_cnt_d;
  logic [DATAWIDTH-1:0] skid_head_q, skid_head_d;
  logic [DATAWIDTH-1:0] skid_tail_q, skid_tail_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ram_enable_q;

  logic                 push_s;
  logic                 pop_s;
  logic                 rd_issue_s;
  logic [2:0]           skid_need_s;

  assign push_s      = in_valid & in_ready_q;
  assign pop_s       = out_valid_q & out_ready;
  // Skid slots still committed after this cycle's pop; a new read only fits if below 2.
  assign skid_need_s = {1'b0, skid_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop_s};
  assign rd_issue_s  = (ram_cnt_q != {CW{1'b0}}) && (skid_need_s < 3'd2);

  // Pointer, occupancy and ready/level next-state.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_inflight_d = rd_issue_s;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ADDRWIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_issue_s) begin
      rd_ptr_d = rd_ptr_q + ADDRWIDTH'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    ram_cnt_d  = ram_cnt_q + CW'(push_s) - CW'(rd_issue_s);
    in_ready_d = ~ram_cnt_d[ADDRWIDTH];
    level_d    = LW'(ram_cnt_d) + LW'(rd_inflight_d) + LW'(skid_cnt_d);
  end

  // Skid next-state: load returning RAM word, advance head on pop.
  always_comb begin
    skid_head_d = skid_head_q;
    skid_tail_d = skid_tail_q;
    skid_cnt_d  = skid_cnt_q;
    if (rd_inflight_q) begin
      case (skid_cnt_q)
        2'd0: begin
          skid_head_d = ram_rd_data;
          skid_cnt_d  = 2'd1;
        end
        2'd1: begin
          if (pop_s) begin
            skid_head_d = ram_rd_data;
            skid_cnt_d  = 2'd1;
          end else begin
            skid_tail_d = ram_rd_data;
            skid_cnt_d  = 2'd2;
          end
        end
        2'd2: begin
          // Only reachable with a pop, since the issue rule reserved this slot.
          skid_head_d = skid_tail_q;
          skid_tail_d = ram_rd_data;
          skid_cnt_d  = 2'd2;
        end
        default: begin
          skid_cnt_d = skid_cnt_q;
        end
      endcase
    end else if (pop_s) begin
      if (skid_cnt_q == 2'd2) begin
        skid_head_d = skid_tail_q;
        skid_cnt_d  = 2'd1;
      end else begin
        skid_cnt_d  = 2'd0;
      end
    end else begin
      skid_cnt_d = skid_cnt_q;
    end
    out_valid_d = (skid_cnt_d != 2'd0);
  end

  // State registers; reset discards all held and in-flight words.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr_q      <= {ADDRWIDTH{1'b0}};
      rd_ptr_q      <= {ADDRWIDTH{1'b0}};
      ram_cnt_q     <= {CW{1'b0}};
      rd_inflight_q <= 1'b0;
      skid_cnt_q    <= 2'd0;
      skid_head_q   <= {DATAWIDTH{1'b0}};
      skid_tail_q   <= {DATAWIDTH{1'b0}};
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      level_q       <= {LW{1'b0}};
      ram_enable_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      skid_cnt_q    <= skid_cnt_d;
      skid_head_q   <= skid_head_d;
      skid_tail_q   <= skid_tail_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      level_q       <= level_d;
      ram_enable_q  <= 1'b1;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_data    = skid_head_q;
  assign out_valid   = out_valid_q;
  assign level       = level_q;
  assign ram_enable  = ram_enable_q;
  assign ram_wr_data = in_data;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_we      = push_s;
  assign ram_rd_addr = rd_ptr_q;

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
// Directed bench for fifo_ctrl_dp with a behavioural dual-port RAM and a queue model.
module tb_fifo_ctrl_dp;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] level;
  logic        ram_enable;
  logic [7:0]  ram_wr_data;
  logic [8:0]  ram_wr_addr;
  logic        ram_we;
  logic [8:0]  ram_rd_addr;
  logic [7:0]  ram_rd_data;

  logic [7:0]  mem [0:511];
  logic [7:0]  q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_lvl = 0;
  int          n_push = 0;
  int          n_pop = 0;
  logic [7:0]  last_pop = 8'h00;

  fifo_ctrl_dp #(.DATAWIDTH(8), .ADDRWIDTH(9)) dut (
    .clk(clk), .reset_l(reset_l),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .ram_enable(ram_enable),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_we(ram_we),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM, registered read.
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= mem[ram_rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, predict handshakes, advance, check level.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy);
    logic push, pop;
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    push = iv & in_ready;
    pop  = out_valid & ordy;
    chk("ready_at_full", {31'd0, in_ready & (level == 11'd514)}, 32'd0);
    if (push) begin
      q.push_back(d);
      n_push++;
    end
    if (pop) begin
      chk("pop_has_data", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        last_pop = q.pop_front();
        chk("order", {24'd0, out_data}, {24'd0, last_pop});
      end
      n_pop++;
    end
    exp_lvl = exp_lvl + int'(push) - int'(pop);
    @(posedge clk); #1;
    chk("level", {21'd0, level}, exp_lvl);
  endtask

  initial begin
    int p0, c0, guard;
    reset_l = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_level", {21'd0, level}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_enable}, 32'd0);
    #2 reset_l = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_ram_en", {31'd0, ram_enable}, 32'd1);

    // Single word latency: push in cycle 0, visible in cycle 3 only.
    cyc(1'b1, 8'hA5, 1'b1);
    chk("lat_c1_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_c1_level", {21'd0, level}, 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("lat_c2_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("lat_c3_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_c3_data", {24'd0, out_data}, 32'h0000_00A5);
    cyc(1'b0, 8'h00, 1'b1);
    chk("lat_c4_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_c4_hold", {24'd0, out_data}, 32'h0000_00A5);
    chk("lat_c4_level", {21'd0, level}, 32'd0);

    // Full-rate stream of 1024 words: every push accepted, no output gaps.
    p0 = n_push; c0 = n_pop;
    for (int i = 0; i < 1024; i++) cyc(1'b1, 8'(i), 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    chk("stream_pushes", n_push - p0, 32'd1024);
    chk("stream_pops", n_pop - c0, 32'd1024);
    chk("stream_empty", q.size(), 32'd0);

    // Fill with consumer stalled.
    p0 = n_push;
    for (int i = 0; i < 530; i++) cyc(1'b1, 8'(i * 3), 1'b0);
    chk("full_accepted", n_push - p0, 32'd514);
    chk("full_level", {21'd0, level}, 32'd514);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("pop_frees_ready", {31'd0, in_ready}, 32'd1);
    chk("pop_level", {21'd0, level}, 32'd513);

    // Toggle consumer while held near full.
    for (int i = 0; i < 200; i++) cyc(1'b1, 8'(i + 100), 1'(i));
    guard = 0;
    while (q.size() != 0 && guard < 700) begin
      cyc(1'b0, 8'h00, 1'b1);
      guard++;
    end
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    chk("drain_bound", {31'd0, guard < 700}, 32'd1);
    chk("drain_level", {21'd0, level}, 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of reads.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    #2 reset_l = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_level", {21'd0, level}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    q.delete(); exp_lvl = 0;
    repeat (2) @(posedge clk);
    #3 reset_l = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_level", {21'd0, level}, 32'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    c0 = n_pop;
    cyc(1'b1, 8'h3C, 1'b1);
    repeat (4) cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_pops", n_pop - c0, 32'd1);
    chk("post_rst_word", {24'd0, last_pop}, 32'h0000_003C);

    // Random handshakes, 10k words.
    p0 = n_push; guard = 0;
    while ((n_push - p0) < 10000 && guard < 60000) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("rand_pushes", n_push - p0, 32'd10000);
    guard = 0;
    while (q.size() != 0 && guard < 700) begin
      cyc(1'b0, 8'h00, 1'b1);
      guard++;
    end
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    chk("rand_drained", q.size(), 32'd0);
    chk("rand_level", {21'd0, level}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
